// File: rtl/meduram_pkg.sv
// Shared types and helpers for the LVT-based multiport RAM.
// Used by the top, the live value table and the bus interface users.
package meduram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    function automatic int lvt_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/lvt_multiport_ram_if.sv
// Packed multi-agent read/write bus of the LVT multiport RAM.
// The master drives traffic, the slave (the RAM) answers it.
interface lvt_multiport_ram_if #(
    parameter int NB_WRAGENT = 2,
    parameter int NB_RDAGENT = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                           ready;
    logic [NB_WRAGENT-1:0]          wren;
    logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr;
    logic [DATA_WIDTH*NB_WRAGENT-1:0] wrdata;
    logic [NB_RDAGENT-1:0]          rden;
    logic [ADDR_WIDTH*NB_RDAGENT-1:0] rdaddr;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] rddata;
    logic [NB_RDAGENT-1:0]          rdvalid;
    logic                           wrcollision;

    modport master (
        input  ready, rddata, rdvalid, wrcollision,
        output wren, wraddr, wrdata, rden, rdaddr
    );

    modport slave (
        output ready, rddata, rdvalid, wrcollision,
        input  wren, wraddr, wrdata, rden, rdaddr
    );

endinterface

// File: rtl/bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module Bram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  wrclk,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic                  rdclk,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [DATA_WIDTH-1:0] rddata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wrclk) begin
        if (wren) mem[wraddr] <= wrdata;
    end

    always_ff @(posedge rdclk) begin
        if (rden) rddata <= mem[rdaddr];
    end

endmodule

// File: rtl/live_value_table.sv
// Flop-based table recording which write agent last wrote each address.
// Lowest agent index wins a same-address conflict.
module live_value_table
    import meduram_pkg::*;
#(
    parameter int NB_WRAGENT = 2,
    parameter int NB_RDAGENT = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 256,
    parameter int LVT_W      = lvt_width(NB_WRAGENT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic [ADDR_WIDTH-1:0]           clraddr,
    input  logic [NB_WRAGENT-1:0]           wren,
    input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
    output logic [NB_WRAGENT-1:0]           wrwin,
    input  logic [NB_RDAGENT-1:0]           rden,
    input  logic [ADDR_WIDTH*NB_RDAGENT-1:0] rdaddr,
    output logic [LVT_W*NB_RDAGENT-1:0]     rdsel,
    output logic                            collision
);

    logic [LVT_W-1:0] lvt [RAM_DEPTH];
    logic             coll_d;

    always_comb begin
        wrwin  = wren;
        coll_d = 1'b0;
        for (int i = 1; i < NB_WRAGENT; i++) begin
            for (int k = 0; k < i; k++) begin
                if (wren[i] && wren[k] &&
                    wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] ==
                    wraddr[ADDR_WIDTH*k +: ADDR_WIDTH]) begin
                    wrwin[i] = 1'b0;
                    coll_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < RAM_DEPTH; a++) lvt[a] <= '0;
            collision <= 1'b0;
        end else begin
            collision <= coll_d;
            if (clr) lvt[clraddr] <= '0;
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (wrwin[i])
                    lvt[wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]] <= LVT_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdsel <= '0;
        end else begin
            for (int j = 0; j < NB_RDAGENT; j++) begin
                if (rden[j])
                    rdsel[LVT_W*j +: LVT_W] <=
                        lvt[rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH]];
            end
        end
    end

endmodule

// File: rtl/lvt_multiport_ram.sv
// Multi-write/multi-read RAM: one bank per (writer, reader) pair,
// steered by a live value table, with zeroing sweep and RDW bypass.
module lvt_multiport_ram
    import meduram_pkg::*;
#(
    parameter int NB_WRAGENT = 2,
    parameter int NB_RDAGENT = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int RDW_MODE   = RDW_OLD,
    parameter int INIT_ZERO  = 1
) (
    input logic              clk,
    input logic              rst,
    lvt_multiport_ram_if.slave bus
);

    localparam int LVT_W = lvt_width(NB_WRAGENT);

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
    logic                            ready, sweep, collision;
    logic [NB_WRAGENT-1:0]           wren, wrwin;
    logic [NB_RDAGENT-1:0]           rden;
    logic [LVT_W*NB_RDAGENT-1:0]     rdsel;
    logic [DATA_WIDTH-1:0]           bankq [NB_WRAGENT][NB_RDAGENT];
    logic [NB_RDAGENT-1:0]           rdvalid_q, rdok_q;
    logic [NB_RDAGENT-1:0]           byp_q, byp_d;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] bypdata_q, bypdata_d;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] rddata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (INIT_ZERO == 0 ||
                    cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1))
                    state_d = RUN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            RUN: state_d = RUN;
        endcase
    end

    assign ready = (state_q == RUN);
    assign sweep = (state_q == INIT) && (INIT_ZERO != 0);
    assign wren  = bus.wren & {NB_WRAGENT{ready}};
    assign rden  = bus.rden & {NB_RDAGENT{ready}};

    live_value_table #(
        .NB_WRAGENT (NB_WRAGENT),
        .NB_RDAGENT (NB_RDAGENT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .LVT_W      (LVT_W)
    ) u_lvt (
        .clk       (clk),
        .rst       (rst),
        .clr       (sweep),
        .clraddr   (cnt_q),
        .wren      (wren),
        .wraddr    (bus.wraddr),
        .wrwin     (wrwin),
        .rden      (rden),
        .rdaddr    (bus.rdaddr),
        .rdsel     (rdsel),
        .collision (collision)
    );

    for (genvar i = 0; i < NB_WRAGENT; i++) begin : g_wr
        logic                  bwe;
        logic [ADDR_WIDTH-1:0] bwa;
        logic [DATA_WIDTH-1:0] bwd;

        // The sweep owns every bank write port while it runs.
        assign bwe = sweep | wrwin[i];
        assign bwa = sweep ? cnt_q
                           : bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH];
        assign bwd = sweep ? '0
                           : bus.wrdata[DATA_WIDTH*i +: DATA_WIDTH];

        for (genvar j = 0; j < NB_RDAGENT; j++) begin : g_rd
            Bram #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (RAM_DEPTH)
            ) u_bank (
                .wrclk  (clk),
                .wren   (bwe),
                .wraddr (bwa),
                .wrdata (bwd),
                .rdclk  (clk),
                .rden   (rden[j]),
                .rdaddr (bus.rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH]),
                .rddata (bankq[i][j])
            );
        end
    end

    always_comb begin
        byp_d     = byp_q;
        bypdata_d = bypdata_q;
        for (int j = 0; j < NB_RDAGENT; j++) begin
            if (rden[j]) begin
                byp_d[j] = 1'b0;
                if (RDW_MODE == RDW_NEW) begin
                    for (int i = 0; i < NB_WRAGENT; i++) begin
                        if (wrwin[i] &&
                            bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] ==
                            bus.rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH]) begin
                            byp_d[j] = 1'b1;
                            bypdata_d[DATA_WIDTH*j +: DATA_WIDTH] =
                                bus.wrdata[DATA_WIDTH*i +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdvalid_q <= '0;
            rdok_q    <= '0;
            byp_q     <= '0;
            bypdata_q <= '0;
        end else begin
            rdvalid_q <= rden;
            rdok_q    <= rdok_q | rden;
            byp_q     <= byp_d;
            bypdata_q <= bypdata_d;
        end
    end

    // Bank outputs are not reset, so a port shows zero until its first read.
    always_comb begin
        logic [LVT_W-1:0]      sel;
        logic [DATA_WIDTH-1:0] word;
        rddata = '0;
        sel    = '0;
        word   = '0;
        for (int j = 0; j < NB_RDAGENT; j++) begin
            sel  = rdsel[LVT_W*j +: LVT_W];
            word = bankq[sel][j];
            if (byp_q[j]) word = bypdata_q[DATA_WIDTH*j +: DATA_WIDTH];
            if (!rdok_q[j]) word = '0;
            rddata[DATA_WIDTH*j +: DATA_WIDTH] = word;
        end
    end

    assign bus.ready       = ready;
    assign bus.rddata      = rddata;
    assign bus.rdvalid     = rdvalid_q;
    assign bus.wrcollision = collision;

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed bench for lvt_multiport_ram: old-data, new-data and
// no-sweep variants driven with identical traffic.
module tb_lvt_multiport_ram;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NW-1:0]    wren;
    logic [AW*NW-1:0] wraddr;
    logic [DW*NW-1:0] wrdata;
    logic [NR-1:0]    rden;
    logic [AW*NR-1:0] rdaddr;

    int errors = 0;
    int checks = 0;

    lvt_multiport_ram_if #(.NB_WRAGENT(NW), .NB_RDAGENT(NR),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
    lvt_multiport_ram_if #(.NB_WRAGENT(NW), .NB_RDAGENT(NR),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
    lvt_multiport_ram_if #(.NB_WRAGENT(NW), .NB_RDAGENT(NR),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();

    assign b0.wren = wren;   assign b1.wren = wren;   assign b2.wren = wren;
    assign b0.wraddr = wraddr; assign b1.wraddr = wraddr; assign b2.wraddr = wraddr;
    assign b0.wrdata = wrdata; assign b1.wrdata = wrdata; assign b2.wrdata = wrdata;
    assign b0.rden = rden;   assign b1.rden = rden;   assign b2.rden = rden;
    assign b0.rdaddr = rdaddr; assign b1.rdaddr = rdaddr; assign b2.rdaddr = rdaddr;

    lvt_multiport_ram #(.NB_WRAGENT(NW), .NB_RDAGENT(NR), .ADDR_WIDTH(AW),
        .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .RDW_MODE(0), .INIT_ZERO(1))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    lvt_multiport_ram #(.NB_WRAGENT(NW), .NB_RDAGENT(NR), .ADDR_WIDTH(AW),
        .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .RDW_MODE(1), .INIT_ZERO(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    lvt_multiport_ram #(.NB_WRAGENT(NW), .NB_RDAGENT(NR), .ADDR_WIDTH(AW),
        .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .RDW_MODE(0), .INIT_ZERO(0))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic quiet();
        wren = '0;
        rden = '0;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        wren[i] = 1'b1;
        wraddr[AW*i +: AW] = a;
        wrdata[DW*i +: DW] = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        rden[j] = 1'b1;
        rdaddr[AW*j +: AW] = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        wraddr = '0; wrdata = '0; rdaddr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b0.ready, b0.rdvalid, b0.wrcollision} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {b0.ready, b0.rdvalid, b0.wrcollision});
        end
        checks++;
        if (b0.rddata !== '0) begin
            errors++;
            $display("FAIL reset_rddata got=%h exp=0", b0.rddata);
        end
        checks++;
        if (b2.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_nozero got=%b exp=0", b2.ready);
        end
    endtask

    task automatic test_init();
        int rise = -1;
        logic bad_valid = 1'b0;
        rst = 1'b0;
        // Traffic during the sweep must be ignored.
        set_wr(1, 8'h05, 32'hDEAD_BEEF);
        set_rd(0, 8'h05);
        set_rd(1, 8'h05);
        for (int k = 1; k <= 300 && rise < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (b2.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL nozero_ready_c1 got=%b exp=1", b2.ready);
                end
            end
            if (b0.rdvalid !== 2'b00) bad_valid = 1'b1;
            if (b0.ready === 1'b1) begin
                rise = k;
                quiet();
            end
        end
        quiet();
        checks++;
        if (rise != DEPTH) begin
            errors++;
            $display("FAIL init_ready_cycle got=%0d exp=%0d", rise, DEPTH);
        end
        checks++;
        if (bad_valid) begin
            errors++;
            $display("FAIL init_rdvalid got=1 exp=0");
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(DEPTH - 1 - a));
            @(negedge clk);
            checks++;
            if ({b0.rdvalid, b0.rddata, b1.rdvalid, b1.rddata} !==
                {2'b11, 64'h0, 2'b11, 64'h0}) begin
                errors++;
                $display("FAIL zero_read a=%0d got=%b/%h %b/%h exp=11/0",
                         a, b0.rdvalid, b0.rddata, b1.rdvalid, b1.rddata);
            end
        end
        quiet();
        @(negedge clk);
    endtask

    task automatic test_cross();
        set_wr(0, 8'h10, 32'hAAAA_5555);
        set_wr(1, 8'h20, 32'h1234_5678);
        @(negedge clk);
        quiet();
        checks++;
        if (b0.wrcollision !== 1'b0) begin
            errors++;
            $display("FAIL cross_nocoll got=%b exp=0", b0.wrcollision);
        end
        set_rd(0, 8'h20);
        set_rd(1, 8'h10);
        @(negedge clk);
        quiet();
        checks++;
        if ({b0.rdvalid, b0.rddata} !== {2'b11, 64'hAAAA5555_12345678}) begin
            errors++;
            $display("FAIL cross_rd got=%b/%h exp=11/aaaa555512345678",
                     b0.rdvalid, b0.rddata);
        end
        checks++;
        if (b1.rddata !== 64'hAAAA5555_12345678) begin
            errors++;
            $display("FAIL cross_rd_new got=%h exp=aaaa555512345678",
                     b1.rddata);
        end
    endtask

    task automatic test_collision();
        set_wr(0, 8'h33, 32'h1);
        set_wr(1, 8'h33, 32'h2);
        @(negedge clk);
        quiet();
        checks++;
        if (b0.wrcollision !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse got=%b exp=1", b0.wrcollision);
        end
        set_rd(0, 8'h33);
        set_rd(1, 8'h33);
        @(negedge clk);
        quiet();
        checks++;
        if (b0.wrcollision !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear got=%b exp=0", b0.wrcollision);
        end
        @(negedge clk);
        checks++;
        if (b0.rddata !== 64'h00000001_00000001) begin
            errors++;
            $display("FAIL coll_winner got=%h exp=0000000100000001",
                     b0.rddata);
        end
    endtask

    task automatic test_rdw();
        set_wr(0, 8'h40, 32'h7);
        @(negedge clk);
        quiet();
        set_wr(1, 8'h40, 32'h9);
        set_rd(0, 8'h40);
        @(negedge clk);
        quiet();
        checks++;
        if (b0.rddata[DW-1:0] !== 32'h7) begin
            errors++;
            $display("FAIL rdw_old got=%h exp=7", b0.rddata[DW-1:0]);
        end
        checks++;
        if (b1.rddata[DW-1:0] !== 32'h9) begin
            errors++;
            $display("FAIL rdw_new got=%h exp=9", b1.rddata[DW-1:0]);
        end
        set_rd(0, 8'h40);
        set_rd(1, 8'h40);
        @(negedge clk);
        quiet();
        checks++;
        if ({b0.rddata, b1.rddata} !== {4{32'h9}}) begin
            errors++;
            $display("FAIL rdw_after got=%h %h exp=9 everywhere",
                     b0.rddata, b1.rddata);
        end
    endtask

    task automatic test_back_to_back();
        set_wr(0, 8'h60, 32'h11);
        set_wr(1, 8'h61, 32'h22);
        @(negedge clk);
        quiet();
        checks++;
        if (b0.wrcollision !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nocoll got=%b exp=0", b0.wrcollision);
        end
        set_wr(0, 8'h61, 32'h33);
        set_rd(0, 8'h61);
        set_rd(1, 8'h60);
        @(negedge clk);
        quiet();
        checks++;
        if (b0.rddata !== 64'h00000011_00000022) begin
            errors++;
            $display("FAIL b2b_old got=%h exp=0000001100000022", b0.rddata);
        end
        checks++;
        if (b1.rddata !== 64'h00000011_00000033) begin
            errors++;
            $display("FAIL b2b_new got=%h exp=0000001100000033", b1.rddata);
        end
        set_rd(0, 8'h61);
        @(negedge clk);
        quiet();
        checks++;
        if ({b0.rdvalid, b0.rddata[DW-1:0]} !== {2'b01, 32'h33}) begin
            errors++;
            $display("FAIL b2b_switch got=%b/%h exp=01/33",
                     b0.rdvalid, b0.rddata[DW-1:0]);
        end
    endtask

    task automatic test_idle_hold();
        set_wr(1, 8'h50, 32'h5A);
        @(negedge clk);
        quiet();
        set_rd(1, 8'h50);
        @(negedge clk);
        quiet();
        checks++;
        if ({b0.rdvalid, b0.rddata[2*DW-1:DW]} !== {2'b10, 32'h5A}) begin
            errors++;
            $display("FAIL idle_first got=%b/%h exp=10/5a",
                     b0.rdvalid, b0.rddata[2*DW-1:DW]);
        end
        set_wr(0, 8'h50, 32'hFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            quiet();
            checks++;
            if ({b0.rdvalid, b0.rddata[2*DW-1:DW],
                 b1.rdvalid, b1.rddata[2*DW-1:DW]} !==
                {2'b00, 32'h5A, 2'b00, 32'h5A}) begin
                errors++;
                $display("FAIL idle_hold c=%0d got=%b/%h %b/%h exp=00/5a",
                         c, b0.rdvalid, b0.rddata[2*DW-1:DW],
                         b1.rdvalid, b1.rddata[2*DW-1:DW]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        rst = 1'b1;
        set_rd(0, 8'h10);
        set_rd(1, 8'h20);
        @(negedge clk);
        quiet();
        checks++;
        if ({b0.ready, b0.rdvalid} !== 3'b000 || b0.rddata !== '0) begin
            errors++;
            $display("FAIL rst_traffic got=%b%b/%h exp=000/0",
                     b0.ready, b0.rdvalid, b0.rddata);
        end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (b0.ready !== 1'b0) begin
            errors++;
            $display("FAIL sweep_mid_ready got=%b exp=0", b0.ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 300 && rise < 0; k++) begin
            @(negedge clk);
            if (b0.ready === 1'b1) rise = k;
        end
        checks++;
        if (rise != DEPTH) begin
            errors++;
            $display("FAIL resweep_ready_cycle got=%0d exp=%0d", rise, DEPTH);
        end
        set_rd(0, 8'h10);
        set_rd(1, 8'h50);
        @(negedge clk);
        quiet();
        checks++;
        if ({b0.rdvalid, b0.rddata} !== {2'b11, 64'h0}) begin
            errors++;
            $display("FAIL resweep_zero got=%b/%h exp=11/0",
                     b0.rdvalid, b0.rddata);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_cross();
        test_collision();
        test_rdw();
        test_back_to_back();
        test_idle_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lvt_multiport_ram.md
# lvt_multiport_ram

- Multi-write / multi-read RAM with `NB_WRAGENT` write ports and `NB_RDAGENT` read ports.
- Built from one simple-dual-port bank per (write agent, read agent) pair, plus a register-based live value table (LVT) that records which agent last wrote each address.
- Adds to the existing per-agent bank array:
  - cross-agent reads (any read port sees any writer's data),
  - write-conflict arbitration,
  - selectable read-during-write behaviour,
  - a post-reset zeroing sweep.

## Interface
- `NB_WRAGENT`, 2, number of write ports (≥1)
- `NB_RDAGENT`, 2, number of read ports (≥1)
- `ADDR_WIDTH`, 8, address width in bits
- `RAM_DEPTH`, 2**ADDR_WIDTH, words per bank (≤2**ADDR_WIDTH)
- `DATA_WIDTH`, 32, data width in bits
- `RDW_MODE`, 0, same-address read-during-write: 0 = old data, 1 = new data (bypass)
- `INIT_ZERO`, 1, 1 = sweep all banks to zero after reset; 0 = clear LVT only
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ready`  out  1  high when ports accept traffic
- `wren`  in  NB_WRAGENT  per-agent write enable
- `wraddr`  in  ADDR_WIDTH*NB_WRAGENT  packed write addresses, agent i at `[ADDR_WIDTH*i +: ADDR_WIDTH]`
- `wrdata`  in  DATA_WIDTH*NB_WRAGENT  packed write data
- `rden`  in  NB_RDAGENT  per-port read enable
- `rdaddr`  in  ADDR_WIDTH*NB_RDAGENT  packed read addresses
- `rddata`  out  DATA_WIDTH*NB_RDAGENT  packed read data
- `rdvalid`  out  NB_RDAGENT  `rddata` slice valid this cycle
- `wrcollision`  out  1  one-cycle pulse: two or more agents wrote the same address in the previous cycle

## Operation
- **State machine:** `INIT` → `RUN`. Reset forces `INIT` with sweep counter = 0.
- **`INIT`, `INIT_ZERO`=1:**
  - Each cycle, address = counter; write 0 to every bank; set LVT entry to 0.
  - Counter increments; at `RAM_DEPTH-1` go to `RUN`.
- **`INIT`, `INIT_ZERO`=0:**
  - LVT flops cleared by reset; go to `RUN` on the first cycle after reset.
- **`INIT` (both modes):** `ready`=0; `wren`/`rden` ignored; `rdvalid` held 0.
- **Write (`RUN`):**
  - Agent i with `wren[i]` writes `wrdata_i` at `wraddr_i` into banks B[i][0..NB_RDAGENT-1].
  - Same cycle, LVT[`wraddr_i`] ← i.
- **Write conflict:**
  - Agents sharing an address in one cycle: lowest index wins.
  - Losing agents' bank writes and LVT updates are suppressed.
  - `wrcollision` pulses on the next cycle.
- **Read (`RUN`):**
  - Port j with `rden[j]` at cycle T reads LVT[`rdaddr_j`] and B[k][j][`rdaddr_j`] for all k.
  - Cycle T+1: `rddata_j` = B[LVT value][j] output; `rdvalid[j]`=1.
- **Read-during-write, same address, same cycle:**
  - `RDW_MODE`=0: returns the pre-write word.
  - `RDW_MODE`=1: returns the winning writer's `wrdata`, via a bypass register.
- **Idle read port:** `rden[j]`=0 → `rddata_j` holds its last value; `rdvalid[j]`=0.
- **LVT entry width:** `LVT_W` = max(1, clog2(`NB_WRAGENT`)).
- **Out-of-range addresses:** addresses ≥ `RAM_DEPTH` are don't-care (no protection).

## Timing
- **Reset values:** `ready`=0, `rdvalid`=0, `rddata`=0, `wrcollision`=0, state=`INIT`, counter=0.
- **`ready` after `rst` falls (first cycle low = cycle 0):**
  - `INIT_ZERO`=1: `ready` rises at cycle `RAM_DEPTH`.
  - `INIT_ZERO`=0: `ready` rises at cycle 1.
- **Read latency:** exactly 1 cycle; fully pipelined, one read per port per cycle.
- **Write latency:** a read issued the cycle after a write returns the new data, in either `RDW_MODE`.
- **`rst` mid-sweep or mid-traffic:**
  - Restarts the sweep from 0.
  - Any in-flight read is dropped: `rdvalid`=0 next cycle.
- **Simultaneous write of all agents to distinct addresses:** all complete in one cycle; no collision.

## Structure
- **Package `meduram_pkg`:**
  - `LVT_W` computation function.
  - `RDW_OLD` / `RDW_NEW` constants.
  - State enum `{INIT, RUN}`.
- **Sub-module `live_value_table`:**
  - `RAM_DEPTH` × `LVT_W` flop array.
  - `NB_WRAGENT` write ports with lowest-index arbitration and collision detect.
  - `NB_RDAGENT` registered read ports.
- **Banks:** `NB_WRAGENT`×`NB_RDAGENT` instances of the team's existing simple-dual-port `Bram`, tied to `clk` on both sides.
- **Top level:** init FSM/counter, write mux (sweep vs agents), output mux, RDW bypass.

## Test plan
- **Reset + init:** `INIT_ZERO`=1, `RAM_DEPTH`=256. Deassert `rst` → `ready` rises at cycle 256. Reading all addresses on every port returns 0.
- **Cross-agent read:**
  - Agent 0 writes 0xAAAA5555 @0x10; agent 1 writes 0x12345678 @0x20.
  - Next cycle port 0 reads 0x20 and port 1 reads 0x10 → 0x12345678 / 0xAAAA5555, with `rdvalid`=11 one cycle later.
- **Collision:**
  - Agents 0 and 1 both write @0x33 (0x1 / 0x2) → `wrcollision` pulses one cycle.
  - A later read of 0x33 returns 0x1.
- **Read-during-write:**
  - Address 0x40 holds 0x7; agent 1 writes 0x9 while port 0 reads 0x40.
  - `RDW_MODE`=0 → 0x7; `RDW_MODE`=1 → 0x9.
- **Reset mid-sweep:** assert `rst` at sweep count 100 → counter restarts at 0; `ready` stays 0 until 256 cycles after the second deassertion.
- **Idle hold:** read returns 0x5A; drive `rden`=0 for 3 cycles → `rddata` stays 0x5A and `rdvalid`=0.
